// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding, default widths, and the bus mode
// constants that the on-chip master also uses.
package spi_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_e;

    localparam int SPI_DATA_WIDTH  = 8;
    localparam int SPI_SYNC_STAGES = 2;

    localparam bit SPI_CPOL = 1'b0;
    localparam bit SPI_CPHA = 1'b0;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin, with single-cycle rise/fall
// pulses derived from the synchronized level.
module spi_sync_edge #(
    parameter int STAGES  = 2,
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sreg;
    logic              prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sreg <= {STAGES{RST_VAL}};
            prev <= RST_VAL;
        end else begin
            sreg <= {sreg[STAGES-2:0], din};
            prev <= sreg[STAGES-1];
        end
    end

    assign rise =  sreg[STAGES-1] & ~prev;
    assign fall = ~sreg[STAGES-1] &  prev;

endmodule

// File: rtl/spi_slave.sv
// Oversampled SPI slave (mode 0, MSB first, full duplex) with a word-wide
// fabric interface. Define SPI_SLAVE_MISO_HIZ_EN to tri-state miso when not selected.
module spi_slave
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH  = SPI_DATA_WIDTH,
    parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sclk,
    input  logic                  ss,
    input  logic                  mosi,
    output logic                  miso,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_ack,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy
);

    localparam int CNT_W          = $clog2(DATA_WIDTH);
    localparam bit SAMPLE_ON_RISE = (SPI_CPOL == SPI_CPHA);

    spi_state_e state, state_next;

    logic sclk_rise, sclk_fall, ss_rise, ss_fall;
    logic sample_edge, shift_edge;

    logic [SYNC_STAGES-1:0] mosi_sreg;
    logic                   mosi_sync;

    logic [CNT_W-1:0]       bit_cnt;
    logic                   reload;
    logic [DATA_WIDTH-1:0]  tx_shift;
    logic [DATA_WIDTH-2:0]  rx_shift;
    logic [DATA_WIDTH-1:0]  rx_next;

    // sclk idles at CPOL, ss idles deasserted
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(SPI_CPOL)) u_sclk_sync (
        .clk   (clk),
        .reset (reset),
        .din   (sclk),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
        .clk   (clk),
        .reset (reset),
        .din   (ss),
        .rise  (ss_rise),
        .fall  (ss_fall)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) mosi_sreg <= '0;
        else       mosi_sreg <= {mosi_sreg[SYNC_STAGES-2:0], mosi};
    end

    assign mosi_sync   = mosi_sreg[SYNC_STAGES-1];
    assign sample_edge = SAMPLE_ON_RISE ? sclk_rise : sclk_fall;
    assign shift_edge  = SAMPLE_ON_RISE ? sclk_fall : sclk_rise;
    assign rx_next     = {rx_shift, mosi_sync};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (ss_fall) state_next = ACTIVE;
            end
            ACTIVE: begin
                busy = 1'b1;
                if (ss_rise) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // ss events take priority over any sclk edge detected in the same cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt  <= '0;
            reload   <= 1'b0;
            tx_shift <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            tx_ack   <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            tx_ack   <= 1'b0;
            if (state == IDLE) begin
                if (ss_fall) begin
                    tx_shift <= tx_data;
                    bit_cnt  <= '0;
                    reload   <= 1'b0;
                    tx_ack   <= 1'b1;
                end
            end else if (ss_rise) begin
                bit_cnt <= '0;
                reload  <= 1'b0;
            end else if (sample_edge) begin
                rx_shift <= rx_next[DATA_WIDTH-2:0];
                if (bit_cnt == CNT_W'(DATA_WIDTH-1)) begin
                    rx_data  <= rx_next;
                    rx_valid <= 1'b1;
                    bit_cnt  <= '0;
                    reload   <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end else if (shift_edge) begin
                if (reload) begin
                    tx_shift <= tx_data;
                    tx_ack   <= 1'b1;
                    reload   <= 1'b0;
                end else begin
                    tx_shift <= tx_shift << 1;
                end
            end
        end
    end

`ifdef SPI_SLAVE_MISO_HIZ_EN
    assign miso = (state == ACTIVE) ? tx_shift[DATA_WIDTH-1] : 1'bz;
`else
    assign miso = (state == ACTIVE) & tx_shift[DATA_WIDTH-1];
`endif

endmodule
